// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the execute-stage hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_ALU = 2'b01,
    FWD_ALT = 2'b11
  } fwd_sel_e;
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    FLUSH     = 2'd2
  } ctrl_state_e;
  localparam logic [3:0] REG_PC = 4'd15;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decoder-side instruction bus and datapath control outputs
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;
  logic        dec_valid;
  logic [3:0]  dec_A_addr;
  logic [3:0]  dec_B_addr;
  logic [3:0]  dec_shift_addr;
  logic        dec_use_A;
  logic        dec_use_B;
  logic        dec_use_S;
  logic        dec_wr_en;
  logic [3:0]  dec_wr_addr;
  logic        dec_is_ldr;
  logic        dec_is_branch;
  fwd_sel_e    sel_A_in;
  fwd_sel_e    sel_B_in;
  fwd_sel_e    sel_shift_in;
  logic        en_A;
  logic        en_B;
  logic        en_S;
  logic        stall;
  logic        flush;
  ctrl_state_e ctrl_state;
  modport master (
    output dec_valid, dec_A_addr, dec_B_addr, dec_shift_addr, dec_use_A, dec_use_B, dec_use_S,
           dec_wr_en, dec_wr_addr, dec_is_ldr, dec_is_branch,
    input  sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S, stall, flush, ctrl_state
  );
  modport slave (
    input  dec_valid, dec_A_addr, dec_B_addr, dec_shift_addr, dec_use_A, dec_use_B, dec_use_S,
           dec_wr_en, dec_wr_addr, dec_is_ldr, dec_is_branch,
    output sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S, stall, flush, ctrl_state
  );
endinterface

// File: rtl/ldr_scoreboard.sv
// ldr_scoreboard: tracks the single in-flight load and flags load-use hazards in decode
module ldr_scoreboard #(
  parameter int LDR_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [3:0] ld_addr,
  input  logic [3:0] a_addr,
  input  logic [3:0] b_addr,
  input  logic [3:0] s_addr,
  input  logic       use_a,
  input  logic       use_b,
  input  logic       use_s,
  input  logic       is_ldr,
  output logic       lu,
  output logic       ldr_last
);
  logic [2:0] ldr_cnt;
  logic [3:0] ldr_addr;
  logic       ldr_busy;
  assign ldr_busy = ldr_cnt != 3'd0;
  assign ldr_last = ldr_cnt <= 3'd1;
  // a second load is held back too, since there is only one tracking entry
  assign lu = ldr_busy & ((use_a & (ldr_addr == a_addr)) | (use_b & (ldr_addr == b_addr)) |
                          (use_s & (ldr_addr == s_addr)) | is_ldr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ldr_cnt  <= 3'd0;
      ldr_addr <= 4'd0;
    end else if (ld) begin
      ldr_cnt  <= 3'(LDR_LAT);
      ldr_addr <= ld_addr;
    end else if (ldr_busy) begin
      ldr_cnt  <= ldr_cnt - 3'd1;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: issue, forwarding, load-use stall and branch flush sequencing for execute
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LDR_LAT      = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  ctrl_state_e state, state_nx;
  logic [1:0]  fcnt;
  logic        ex_valid, ex_wr_en, ex_is_ldr;
  logic [3:0]  ex_wr_addr;
  logic        ex_fwd, hit_a, hit_b, hit_s;
  logic        lu, ldr_last, hazard, issue;
  ldr_scoreboard #(.LDR_LAT(LDR_LAT)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld       (issue & bus.dec_is_ldr),
    .ld_addr  (bus.dec_wr_addr),
    .a_addr   (bus.dec_A_addr),
    .b_addr   (bus.dec_B_addr),
    .s_addr   (bus.dec_shift_addr),
    .use_a    (bus.dec_use_A),
    .use_b    (bus.dec_use_B),
    .use_s    (bus.dec_use_S),
    .is_ldr   (bus.dec_is_ldr),
    .lu       (lu),
    .ldr_last (ldr_last)
  );
  assign ex_fwd = ex_valid & ex_wr_en & !ex_is_ldr;
  assign hit_a  = bus.dec_use_A & ex_fwd & (ex_wr_addr == bus.dec_A_addr);
  assign hit_b  = bus.dec_use_B & ex_fwd & (ex_wr_addr == bus.dec_B_addr);
  assign hit_s  = bus.dec_use_S & ex_fwd & (ex_wr_addr == bus.dec_shift_addr);
  assign hazard = (state == RUN) & bus.dec_valid & lu;
  // rst_n gates issue so the enables read zero for the whole reset window
  assign issue  = rst_n & (state == RUN) & bus.dec_valid & !lu;
  always_comb begin
    state_nx = state == RUN       ? (hazard ? LOAD_WAIT : (issue & bus.dec_is_branch) ? FLUSH : RUN) :
               state == LOAD_WAIT ? (ldr_last ? RUN : LOAD_WAIT) :
                                    (fcnt <= 2'd1 ? RUN : FLUSH);
    bus.sel_A_in     = bus.dec_A_addr == REG_PC ? FWD_ALT : hit_a ? FWD_ALU : FWD_RF;
    bus.sel_B_in     = hit_b ? FWD_ALU : FWD_RF;
    bus.sel_shift_in = !bus.dec_use_S ? FWD_ALT : hit_s ? FWD_ALU : FWD_RF;
    bus.en_A         = issue;
    bus.en_B         = issue;
    bus.en_S         = issue;
    bus.stall        = (state == LOAD_WAIT) | hazard;
    bus.flush        = state == FLUSH;
    bus.ctrl_state   = state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= RUN;
      fcnt       <= 2'd0;
      ex_valid   <= 1'b0;
      ex_wr_en   <= 1'b0;
      ex_wr_addr <= 4'd0;
      ex_is_ldr  <= 1'b0;
    end else begin
      state    <= state_nx;
      fcnt     <= (issue & bus.dec_is_branch) ? 2'(FLUSH_CYCLES) : fcnt != 2'd0 ? fcnt - 2'd1 : fcnt;
      ex_valid <= issue;
      if (issue) begin
        ex_wr_en   <= bus.dec_wr_en;
        ex_wr_addr <= bus.dec_wr_addr;
        ex_is_ldr  <= bus.dec_is_ldr;
      end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stimulus with a queued expectation scoreboard and negedge monitor
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [12:0] exp_q[$];
  string       name_q[$];
  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl #(.LDR_LAT(2), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                     input logic ua, input logic ub, input logic us, input logic wr,
                     input logic [3:0] wa, input logic ldr, input logic br);
    bus.dec_valid      = v;
    bus.dec_A_addr     = a;
    bus.dec_B_addr     = b;
    bus.dec_shift_addr = s;
    bus.dec_use_A      = ua;
    bus.dec_use_B      = ub;
    bus.dec_use_S      = us;
    bus.dec_wr_en      = wr;
    bus.dec_wr_addr    = wa;
    bus.dec_is_ldr     = ldr;
    bus.dec_is_branch  = br;
  endtask

  task automatic expect_out(input string nm, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [1:0] ss, input logic en, input logic st,
                            input logic fl, input logic [1:0] cs);
    exp_q.push_back({sa, sb, ss, en, en, en, st, fl, cs});
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus.sel_A_in, bus.sel_B_in, bus.sel_shift_in, bus.en_A, bus.en_B, bus.en_S,
            bus.stall, bus.flush, bus.ctrl_state};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got selA/B/S=%b/%b/%b en=%b stall=%b flush=%b st=%0d, want selA/B/S=%b/%b/%b en=%b stall=%b flush=%b st=%0d",
                 nm, a[12:11], a[10:9], a[8:7], a[6:4], a[3], a[2], a[1:0],
                 e[12:11], e[10:9], e[8:7], e[6:4], e[3], e[2], e[1:0]);
      end
    end
  end

  initial begin
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(); expect_out("reset",          2'b00, 2'b00, 2'b00, 0, 0, 0, 2'd0);
    cyc(); drv(1, 2, 3, 0, 1, 1, 1, 1, 1, 0, 0);
           expect_out("reset_en_gated", 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'd0);
    cyc(); rst_n = 1'b1;
           expect_out("add_r1",         2'b00, 2'b00, 2'b00, 1, 0, 0, 2'd0);
    cyc(); drv(1, 1, 3, 0, 1, 1, 1, 1, 2, 0, 0);
           expect_out("fwd_a",          2'b01, 2'b00, 2'b00, 1, 0, 0, 2'd0);
    cyc(); drv(1, 3, 2, 2, 1, 1, 1, 1, 15, 0, 0);
           expect_out("fwd_b_s",        2'b00, 2'b01, 2'b01, 1, 0, 0, 2'd0);
    cyc(); drv(1, 15, 15, 0, 1, 1, 0, 1, 7, 0, 0);
           expect_out("pc_alt",         2'b11, 2'b01, 2'b11, 1, 0, 0, 2'd0);
    cyc(); drv(1, 7, 0, 0, 1, 0, 0, 1, 4, 1, 0);
           expect_out("ldr_issue",      2'b01, 2'b00, 2'b11, 1, 0, 0, 2'd0);
    cyc(); drv(1, 0, 4, 0, 1, 1, 1, 1, 5, 0, 0);
           expect_out("lu_stall1",      2'b00, 2'b00, 2'b00, 0, 1, 0, 2'd0);
    cyc(); expect_out("lu_stall2",      2'b00, 2'b00, 2'b00, 0, 1, 0, 2'd1);
    cyc(); expect_out("lu_issue",       2'b00, 2'b00, 2'b00, 1, 0, 0, 2'd0);
    cyc(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
           expect_out("br_issue",       2'b00, 2'b00, 2'b11, 1, 0, 0, 2'd0);
    cyc(); drv(1, 5, 0, 0, 1, 0, 1, 1, 8, 0, 0);
           expect_out("flush1",         2'b00, 2'b00, 2'b00, 0, 0, 1, 2'd2);
    cyc(); expect_out("flush2",         2'b00, 2'b00, 2'b00, 0, 0, 1, 2'd2);
    cyc(); expect_out("post_flush",     2'b00, 2'b00, 2'b00, 1, 0, 0, 2'd0);
    cyc(); drv(1, 8, 0, 0, 1, 0, 0, 1, 9, 1, 0);
           expect_out("ldr2_issue",     2'b01, 2'b00, 2'b11, 1, 0, 0, 2'd0);
    cyc(); drv(1, 0, 0, 0, 1, 0, 0, 1, 10, 1, 0);
           expect_out("ldr_ldr_stall",  2'b00, 2'b00, 2'b11, 0, 1, 0, 2'd0);
    cyc(); rst_n = 1'b0;
           drv(1, 9, 4, 0, 1, 1, 1, 1, 11, 0, 0);
           expect_out("rst_mid_wait",   2'b00, 2'b00, 2'b00, 0, 0, 0, 2'd0);
    cyc(); rst_n = 1'b1;
           expect_out("post_rst_issue", 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'd0);
    cyc(); drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
           expect_out("idle",           2'b00, 2'b00, 2'b00, 0, 0, 0, 2'd0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
